mul_seq_if: RTL and testbench
=============================

Name: mul_seq_if

Overview:
- Operand sequencer and result collector placed in front of the 64-bit Booth radix-2 multiplier core.
- Accepts one operand pair over a valid/ready handshake.
- Serialises the operands onto the core's shared 64-bit inbus, pulses bgn, then waits for stop.
- Assembles the two outbus result words into a 128-bit product, returned over a valid/ready handshake, with a watchdog on the core.

Parameters:
- W, 64, operand and bus word width.
- TIMEOUT_CYC, 200, maximum cycles in RUN before the error exit.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  block can accept an operand pair.
- op_m  in  W  multiplicand.
- op_q  in  W  multiplier.
- mul_bgn  out  1  start pulse to the core.
- mul_inbus  out  W  operand bus to the core.
- mul_stop  in  1  core done flag.
- mul_outbus  in  W  result bus from the core.
- res_valid  out  1  product valid.
- res_ready  in  1  consumer accepts the product.
- res_hi  out  W  product bits [2W-1:W] (A register).
- res_lo  out  W  product bits [W-1:0] (Q register).
- err  out  1  sticky watchdog error.

Behaviour:
- Reset is asynchronous and active-low on rst_b and is honoured in every state.
- Reset values: state IDLE, op_ready=1, mul_bgn=0, mul_inbus=0, res_valid=0, res_hi=0, res_lo=0, err=0, watchdog=0, shift pair=0, operand latches=0.
- States: IDLE, START, LOAD_M, LOAD_Q, RUN, DONE, ERR.
- IDLE: op_ready=1. On op_valid&op_ready, latch op_m and op_q and go to START. op_ready is registered and deasserts from the next cycle.
- START: mul_bgn=1 for exactly this one cycle; mul_inbus=0. Next state LOAD_M.
- LOAD_M: mul_inbus=latched M. Next state LOAD_Q.
- LOAD_Q: mul_inbus=latched Q. Next state RUN. The watchdog clears on entry to RUN.
- RUN:
  - mul_inbus=0.
  - Every cycle: sh1<=mul_outbus and sh0<=sh1 (2-deep history).
  - Core contract: A is driven two cycles before stop first rises, Q one cycle before.
  - On the rising edge of mul_stop (stop=1, stop_d=0): res_hi<=sh0, res_lo<=sh1, go to DONE.
  - The watchdog increments each RUN cycle. If it reaches TIMEOUT_CYC without stop, set err=1 and go to ERR.
- DONE: res_valid=1; res_hi and res_lo are held stable. On res_valid&res_ready, go to IDLE.
- DONE backpressure: res_valid stays 1 indefinitely while res_ready=0. No new operand is accepted (op_ready=0).
- mul_stop held high from a previous run does not retrigger; only a 0->1 edge seen in RUN counts.
- mul_stop during START, LOAD_M or LOAD_Q is ignored.
- ERR:
  - op_ready=0, res_valid=0, err=1. The block stays in ERR until reset.
  - err is sticky and cleared only by rst_b.
- Latency from op accept to res_valid = 3 + (core run cycles) + 1.
- Back-to-back: the handshake cycle in DONE returns to IDLE, and a new op can be accepted the following cycle.
- Product is two's complement, full 2W bits. No truncation or arithmetic is performed in this block.

Optional Feature:
- Macro MUL_SEQ_OVF_EN.
- When defined: adds output ovf (1 bit), registered with res_hi/res_lo. ovf=1 when res_hi is not the sign extension of res_lo[W-1], i.e. the product does not fit in W signed bits. Reset 0; valid while res_valid=1.
- When undefined: no ovf port and no comparison logic.

Decomposition:
- Shared package mul_pkg:
  - state enum mul_seq_state_t (IDLE..ERR);
  - localparam MUL_W=64;
  - default TIMEOUT_CYC constant.
- One natural sub-module: mul_res_cap, the 2-deep outbus shift pair plus stop edge detect and result capture registers. The FSM, watchdog and handshakes stay in the top.

Test Plan:
- op_m=3, op_q=5 with a core model (stop after 66 cycles) -> mul_bgn one cycle, mul_inbus 3 then 5 on consecutive cycles, res_hi=0, res_lo=15, res_valid=1.
- op_m=-2, op_q=3 -> res_hi=64'hFFFF_FFFF_FFFF_FFFF, res_lo=64'hFFFF_FFFF_FFFF_FFFA. With MUL_SEQ_OVF_EN: ovf=0. Then 2^40*2^40 -> ovf=1, res_hi=2^16, res_lo=0.
- res_ready held 0 for 20 cycles in DONE -> res_valid and data stable, op_ready=0, second op_valid ignored. res_ready=1 -> IDLE next cycle, next op accepted one cycle later.
- Core model never raises stop -> err=1 exactly TIMEOUT_CYC cycles after entering RUN, state ERR, op_ready=0. rst_b pulse -> all outputs at reset values.
- rst_b asserted mid-RUN, then released -> IDLE, op_ready=1, no res_valid, stale stop level from core does not produce a capture.
- Two back-to-back pairs (7*8, -1*-1) -> results 56 and 1 in order, with no missed or duplicated res_valid.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier sequencer slice.
// Holds the sequencer state encoding and the default bus width and
// watchdog limits used by mul_seq_if and mul_res_cap.
package mul_pkg;

    localparam int MUL_W           = 64;
    localparam int MUL_TIMEOUT_CYC = 200;
    localparam int MUL_CNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_M,
        LOAD_Q,
        RUN,
        DONE,
        ERR
    } mul_seq_state_t;

endpackage

// File: rtl/mul_res_cap.sv
// Result collector for the Booth core.
// Keeps a two-deep history of mul_outbus while the core runs, detects the
// rising edge of mul_stop and captures the A/Q words into res_hi/res_lo.
// Optional overflow flag under `MUL_SEQ_OVF_EN`.
module mul_res_cap
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         run,
    input  logic         mul_stop,
    input  logic [W-1:0] mul_outbus,
    output logic         stop_edge,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo
`ifdef MUL_SEQ_OVF_EN
    ,
    output logic         ovf
`endif
);

    logic [W-1:0] sh0;
    logic [W-1:0] sh1;
    logic         stop_d;

    // A stop level left over from an earlier run has stop_d=1 and is ignored.
    assign stop_edge = run & mul_stop & ~stop_d;

    // Track the previous stop level in every state so stale highs never look like edges.
    always_ff @(posedge clk or negedge rst_b) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values and simulation matches the synthesised flops.
        if (!rst_b) begin
            stop_d <= 1'b0;
        end else begin
            stop_d <= mul_stop;
        end
    end

    // Two-deep outbus history: A lands in sh0 and Q in sh1 on the stop edge cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sh0 <= '0;
            sh1 <= '0;
        end else if (run) begin
            sh1 <= mul_outbus;
            sh0 <= sh1;
        end
    end

    // Capture the product once per run; held stable until the next capture.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            res_hi <= '0;
            res_lo <= '0;
`ifdef MUL_SEQ_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (stop_edge) begin
            res_hi <= sh0;
            res_lo <= sh1;
`ifdef MUL_SEQ_OVF_EN
            ovf    <= (sh0 != {W{sh1[W-1]}});
`endif
        end
    end

endmodule

// File: rtl/mul_seq_if.sv
// Operand sequencer and result collector in front of the Booth radix-2 core.
// Accepts an operand pair, serialises it onto mul_inbus after a bgn pulse,
// waits for the core's stop edge and returns the 2W-bit product.
// A watchdog moves the block into a sticky ERR state if the core hangs.
// Optional overflow output under `MUL_SEQ_OVF_EN`.
module mul_seq_if
    import mul_pkg::*;
#(
    parameter int W           = MUL_W,
    parameter int TIMEOUT_CYC = MUL_TIMEOUT_CYC,
    parameter int CNT_W       = MUL_CNT_W   // 2**CNT_W must exceed TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_m,
    input  logic [W-1:0] op_q,
    output logic         mul_bgn,
    output logic [W-1:0] mul_inbus,
    input  logic         mul_stop,
    input  logic [W-1:0] mul_outbus,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo,
    output logic         err
`ifdef MUL_SEQ_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mul_seq_state_t   state;
    logic [CNT_W-1:0] wdog;
    logic [W-1:0]     m_lat;
    logic [W-1:0]     q_lat;
    logic             run;
    logic             stop_edge;

    assign run = (state == RUN);

    mul_res_cap #(
        .W (W)
    ) u_res_cap (
        .clk        (clk),
        .rst_b      (rst_b),
        .run        (run),
        .mul_stop   (mul_stop),
        .mul_outbus (mul_outbus),
        .stop_edge  (stop_edge),
        .res_hi     (res_hi),
        .res_lo     (res_lo)
`ifdef MUL_SEQ_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    // Sequencer FSM with registered handshake, core-bus and watchdog outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            mul_bgn   <= 1'b0;
            mul_inbus <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            wdog      <= '0;
            m_lat     <= '0;
            q_lat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        m_lat     <= op_m;
                        q_lat     <= op_q;
                        op_ready  <= 1'b0;
                        mul_bgn   <= 1'b1;
                        mul_inbus <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    mul_bgn   <= 1'b0;
                    mul_inbus <= m_lat;
                    state     <= LOAD_M;
                end
                LOAD_M: begin
                    mul_inbus <= q_lat;
                    state     <= LOAD_Q;
                end
                LOAD_Q: begin
                    mul_inbus <= '0;
                    wdog      <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    // A stop edge on the final watchdog cycle still wins over the timeout.
                    if (stop_edge) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else if (wdog == WDOG_LAST) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ERR: begin
                    op_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    err       <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    op_ready  <= 1'b1;
                    mul_bgn   <= 1'b0;
                    mul_inbus <= '0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_if.sv
// Self-checking bench for mul_seq_if with a behavioural Booth core model.
// Expected products are hand-computed and queued on acceptance; a monitor
// pops and compares whenever a result handshake occurs.
module tb_mul_seq_if;

    localparam int W     = 64;
    localparam int TO    = 200;
    localparam int N_RUN = 66;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_m;
    logic [W-1:0] op_q;
    logic         mul_bgn;
    logic [W-1:0] mul_inbus;
    logic         mul_stop;
    logic [W-1:0] mul_outbus;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;
    logic         err;
`ifdef MUL_SEQ_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ov;
        int           acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] q;
    } opnd_t;

    exp_t  sb[$];
    opnd_t opq[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    cyc      = 0;
    int    hs_cyc   = 0;
    bit    no_stop    = 1'b0;
    bit    stale_stop = 1'b0;

    mul_seq_if #(
        .W           (W),
        .TIMEOUT_CYC (TO),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_m       (op_m),
        .op_q       (op_q),
        .mul_bgn    (mul_bgn),
        .mul_inbus  (mul_inbus),
        .mul_stop   (mul_stop),
        .mul_outbus (mul_outbus),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .err        (err)
`ifdef MUL_SEQ_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    // Free-running clock.
    initial forever #5 clk = ~clk;

    // Cycle counter used for latency and timeout measurements.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " op_ready"},  128'(op_ready),  128'(1));
        check({tag, " mul_bgn"},   128'(mul_bgn),   128'(0));
        check({tag, " mul_inbus"}, 128'(mul_inbus), 128'(0));
        check({tag, " res_valid"}, 128'(res_valid), 128'(0));
        check({tag, " res_hi"},    128'(res_hi),    128'(0));
        check({tag, " res_lo"},    128'(res_lo),    128'(0));
        check({tag, " err"},       128'(err),       128'(0));
`ifdef MUL_SEQ_OVF_EN
        check({tag, " ovf"},       128'(ovf),       128'(0));
`endif
    endtask

    // Offer one operand pair (called at a negedge); queue expectations on accept.
    task automatic send(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input logic e_ov, input bit push, output int acc);
        int t = 0;
        op_m     = m;
        op_q     = q;
        op_valid = 1'b1;
        while (!op_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        acc = cyc;
        if (!op_ready) begin
            check("op accept timeout", 128'(0), 128'(1));
            op_valid = 1'b0;
            return;
        end
        opq.push_back('{m: m, q: q});
        if (push) sb.push_back('{hi: e_hi, lo: e_lo, ov: e_ov, acc: cyc});
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Wait until every queued result has been returned.
    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain timeout", 128'(sb.size()), 128'(0));
        @(negedge clk);
    endtask

    // Core model: takes M and Q after bgn, drives A then Q then raises stop.
    initial begin
        int                    ph = 0;
        int                    k  = 0;
        logic [W-1:0]          cm;
        logic [W-1:0]          cq;
        logic signed [2*W-1:0] prod;
        opnd_t                 o;
        mul_stop   = 1'b0;
        mul_outbus = '0;
        cm         = '0;
        cq         = '0;
        prod       = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                ph         = 0;
                mul_stop   = stale_stop;
                mul_outbus = '0;
            end else begin
                case (ph)
                    0: if (mul_bgn) begin
                        check("inbus zero in START", 128'(mul_inbus), 128'(0));
                        mul_stop = stale_stop;
                        ph       = 1;
                    end
                    1: begin
                        check("bgn single cycle", 128'(mul_bgn), 128'(0));
                        cm = mul_inbus;
                        if (opq.size() == 0) check("unexpected core start", 128'(1), 128'(0));
                        else check("inbus M", 128'(mul_inbus), 128'(opq[0].m));
                        ph = 2;
                    end
                    2: begin
                        cq = mul_inbus;
                        if (opq.size() != 0) begin
                            o = opq.pop_front();
                            check("inbus Q", 128'(mul_inbus), 128'(o.q));
                        end
                        prod = $signed({{W{cm[W-1]}}, cm}) * $signed({{W{cq[W-1]}}, cq});
                        k    = 0;
                        ph   = 3;
                    end
                    default: begin
                        if (stale_stop && k == 1) begin
                            mul_stop   = 1'b0;
                            stale_stop = 1'b0;
                        end
                        mul_outbus = W'(k) | 64'hA5A5_0000_0000_0000;
                        if (k == N_RUN - 3) mul_outbus = prod[2*W-1:W];
                        else if (k == N_RUN - 2) mul_outbus = prod[W-1:0];
                        if (k == N_RUN - 1 && !no_stop) begin
                            mul_stop = 1'b1;
                            ph       = 0;
                        end
                        k++;
                    end
                endcase
            end
        end
    end

    // Monitor: latency on each new res_valid, data compare on each handshake.
    initial begin
        bit   prev_v = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_b) begin
                prev_v = 1'b0;
            end else begin
                if (res_valid && !prev_v) begin
                    if (sb.size() == 0) check("spurious res_valid", 128'(res_valid), 128'(0));
                    else check("latency", 128'(cyc - sb[0].acc), 128'(N_RUN + 4));
                end
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected result handshake", 128'(1), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        check("res_hi", 128'(res_hi), 128'(e.hi));
                        check("res_lo", 128'(res_lo), 128'(e.lo));
`ifdef MUL_SEQ_OVF_EN
                        check("ovf", 128'(ovf), 128'(e.ov));
`endif
                    end
                    hs_cyc = cyc;
                end
                prev_v = res_valid;
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        int acc;
        int t;
        rst_b     = 1'b0;
        op_valid  = 1'b0;
        op_m      = '0;
        op_q      = '0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_b = 1'b1;
        @(negedge clk);

        // 3 * 5 = 15
        send(64'd3, 64'd5, 64'd0, 64'd15, 1'b0, 1'b1, acc);
        drain();

        // -2 * 3 = -6, then 2^40 * 2^40 = 2^80
        send(64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b1, acc);
        send(64'h0000_0100_0000_0000, 64'h0000_0100_0000_0000,
             64'h0000_0000_0001_0000, 64'd0, 1'b1, 1'b1, acc);
        drain();

        // Backpressure in DONE: 11 * 2 = 22 held while res_ready=0
        res_ready = 1'b0;
        send(64'd11, 64'd2, 64'd0, 64'd22, 1'b0, 1'b1, acc);
        t = 0;
        while (!res_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("res_valid under backpressure", 128'(res_valid), 128'(1));
        op_m     = 64'd99;
        op_q     = 64'd99;
        op_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("stall res_valid", 128'(res_valid), 128'(1));
            check("stall res_hi",    128'(res_hi),    128'(0));
            check("stall res_lo",    128'(res_lo),    128'(22));
            check("stall op_ready",  128'(op_ready),  128'(0));
            check("stall mul_bgn",   128'(mul_bgn),   128'(0));
        end
        res_ready = 1'b1;
        op_valid  = 1'b0;

        // Back-to-back: 7 * 8 = 56, then -1 * -1 = 1
        send(64'd7, 64'd8, 64'd0, 64'd56, 1'b0, 1'b1, acc);
        check("accept one cycle after handshake", 128'(acc - hs_cyc), 128'(1));
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 1'b0, 1'b1, acc);
        drain();

        // Watchdog: core never raises stop
        no_stop = 1'b1;
        send(64'd1, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0, acc);
        t = 0;
        while (!err && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("err after timeout",      128'(err),       128'(1));
        check("timeout cycle count",    128'(cyc - acc), 128'(TO + 4));
        check("ERR op_ready",           128'(op_ready),  128'(0));
        check("ERR res_valid",          128'(res_valid), 128'(0));
        repeat (5) @(negedge clk);
        check("err sticky",             128'(err),       128'(1));
        check("ERR op_ready held",      128'(op_ready),  128'(0));
        rst_b = 1'b0;
        #1;
        check_reset("reset from ERR");
        no_stop = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("idle after ERR reset", 128'(op_ready), 128'(1));

        // Reset mid-RUN with the core's stop level left high
        send(64'd5, 64'd5, 64'd0, 64'd25, 1'b0, 1'b0, acc);
        repeat (10) @(negedge clk);
        stale_stop = 1'b1;
        rst_b      = 1'b0;
        #1;
        check_reset("mid-run reset");
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post-reset res_valid", 128'(res_valid), 128'(0));
            check("post-reset op_ready",  128'(op_ready),  128'(1));
        end

        // Stale stop held through START..RUN must not trigger an early capture
        send(64'd4, 64'd6, 64'd0, 64'd24, 1'b0, 1'b1, acc);
        drain();

        check("scoreboard empty", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
